// File: rtl/exblock_sequencer.sv
// Sequencer for the step-detect datapath: weight bank, sample handshake, latency wait,
// result capture and a debounced, saturating step counter.
module exblock_sequencer #(
    parameter int DW      = 8,
    parameter int LATENCY = 3,
    parameter int MIN_GAP = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [DW-1:0]    cfg_wdata,
    output logic             cfg_err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_x,
    input  logic [DW-1:0]    s_y,
    output logic [DW-1:0]    dp_A,
    output logic [DW-1:0]    dp_B,
    output logic [DW-1:0]    dp_theta1,
    output logic [DW-1:0]    dp_theta2,
    output logic [DW-1:0]    dp_beta1,
    output logic [DW-1:0]    dp_beta2,
    output logic [DW-1:0]    dp_alpha1,
    output logic [DW-1:0]    dp_alpha2,
    input  logic             dp_step,
    output logic             r_valid,
    output logic             r_step,
    output logic [CNT_W-1:0] step_count,
    input  logic             cnt_clr,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int GAP_W  = $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept;
    logic              wait_zero;
    logic              done_entry;
    logic              cfg_ok;
    logic              counted;

    // Handshake: a pair transfers on any rising edge where s_valid and s_ready are both high;
    // s_ready is high only in IDLE, so the pair and weights are frozen while a sample is in flight.
    assign s_ready    = (state == IDLE) && rst_n;
    assign accept     = s_valid && s_ready;
    assign wait_zero  = (wait_cnt == '0);
    assign done_entry = (state == RUN) && wait_zero;
    assign r_valid    = (state == DONE);
    assign dbg_state  = state;
    assign cfg_ok     = cfg_we && (state == IDLE) && (cfg_addr <= 3'd5);
    assign counted    = dp_step && !r_step && (gap_cnt >= GAP_W'(MIN_GAP));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (wait_zero) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            dp_A     <= '0;
            dp_B     <= '0;
            r_step   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dp_A     <= s_x;
                dp_B     <= s_y;
                wait_cnt <= WAIT_W'(LATENCY - 1);
            end else if (state == RUN && !wait_zero) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (done_entry) r_step <= dp_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_theta1 <= '0;
            dp_theta2 <= '0;
            dp_beta1  <= '0;
            dp_beta2  <= '0;
            dp_alpha1 <= '0;
            dp_alpha2 <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                case (cfg_addr)
                    3'd0:    dp_theta1 <= cfg_wdata;
                    3'd1:    dp_theta2 <= cfg_wdata;
                    3'd2:    dp_beta1  <= cfg_wdata;
                    3'd3:    dp_beta2  <= cfg_wdata;
                    3'd4:    dp_alpha1 <= cfg_wdata;
                    default: dp_alpha2 <= cfg_wdata;
                endcase
            end
        end
    end

    // gap_cnt counts results since the last counted step; reset/clear preload it so the next rise counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count <= '0;
            gap_cnt    <= GAP_W'(MIN_GAP);
        end else if (cnt_clr) begin
            step_count <= '0;
            gap_cnt    <= GAP_W'(MIN_GAP);
        end else if (done_entry) begin
            if (counted) begin
                if (step_count != '1) step_count <= step_count + 1'b1;
                gap_cnt <= '0;
            end else if (gap_cnt < GAP_W'(MIN_GAP)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exblock_sequencer.sv
// Randomized bench for exblock_sequencer with a result-history model of the step debounce
// and an array model of the weight bank.
module tb_exblock_sequencer;

    localparam int DW      = 8;
    localparam int LAT     = 3;
    localparam int MIN_GAP = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          cfg_err;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_x = '0;
    logic [DW-1:0] s_y = '0;
    logic [DW-1:0] dp_A, dp_B;
    logic [DW-1:0] dp_theta1, dp_theta2, dp_beta1, dp_beta2, dp_alpha1, dp_alpha2;
    logic          dp_step = 1'b0;
    logic          r_valid;
    logic          r_step;
    logic [CNT_W-1:0] step_count;
    logic          cnt_clr = 1'b0;
    logic [1:0]    dbg_state;

    exblock_sequencer #(.DW(DW), .LATENCY(LAT), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .dp_A(dp_A), .dp_B(dp_B), .dp_theta1(dp_theta1), .dp_theta2(dp_theta2),
        .dp_beta1(dp_beta1), .dp_beta2(dp_beta2), .dp_alpha1(dp_alpha1), .dp_alpha2(dp_alpha2),
        .dp_step(dp_step), .r_valid(r_valid), .r_step(r_step), .step_count(step_count),
        .cnt_clr(cnt_clr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [DW-1:0] m_w [6];
    int            m_cnt;
    bit            m_prev;
    int            m_nres;
    int            m_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_w();
        return {16'h0, dp_theta1, dp_theta2, dp_beta1, dp_beta2, dp_alpha1, dp_alpha2};
    endfunction

    function automatic logic [63:0] model_w();
        return {16'h0, m_w[0], m_w[1], m_w[2], m_w[3], m_w[4], m_w[5]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_w[i] = '0;
        m_cnt  = 0;
        m_prev = 1'b0;
        m_nres = 0;
        m_last = -MIN_GAP - 1;
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_last = m_nres - MIN_GAP - 1;
    endtask

    // A step counts on a 0->1 result when at least MIN_GAP results separate it from the last counted one.
    task automatic model_result(input bit s, input bit clr);
        int gap;
        gap = m_nres - m_last - 1;
        if (s && !m_prev && gap >= MIN_GAP) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_last = m_nres;
        end
        m_nres++;
        m_prev = s;
        if (clr) model_clear();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_s_ready", s_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_weights", dut_w(), 0);
        check("rst_count", step_count, 0);
        check("rst_dp_ab", {dp_A, dp_B}, 0);
        check("rst_cfg_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (a <= 3'd5) m_w[a] = d;
        check("cfg_err_idle", cfg_err, (a > 3'd5));
        check("cfg_weights", dut_w(), model_w());
    endtask

    // wr_mode: 0 none, 1 write attempt in RUN, 2 write attempt in DONE
    task automatic do_sample(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit s,
                             input bit clr, input int wr_mode, input bit acc_wr);
        int guard = 0;
        logic [2:0] a;
        logic [DW-1:0] d;
        while (!s_ready && guard < 10) begin tick(); guard++; end
        check("ready_before_accept", s_ready, 1);
        s_valid = 1'b1; s_x = x; s_y = y;
        a = 3'($urandom_range(0, 5));
        d = DW'($urandom);
        if (acc_wr) begin cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; end
        tick();
        s_valid = 1'b0; cfg_we = 1'b0; s_x = DW'($urandom); s_y = DW'($urandom);
        if (acc_wr) m_w[a] = d;
        check("dp_ab", {dp_A, dp_B}, {x, y});
        check("run_weights", dut_w(), model_w());
        check("run_cfg_err", cfg_err, 0);
        for (int j = 1; j < LAT; j++) begin
            dp_step = 1'($urandom);
            check("run_ready", s_ready, 0);
            check("run_rvalid", r_valid, 0);
            if (wr_mode == 1 && j == 1) begin
                cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_wdata = DW'($urandom);
            end
            tick();
            if (wr_mode == 1 && j == 1) begin
                cfg_we = 1'b0;
                check("cfg_err_run", cfg_err, 1);
                check("weights_frozen_run", dut_w(), model_w());
            end
        end
        check("pre_done_rvalid", r_valid, 0);
        dp_step = s; cnt_clr = clr;
        tick();
        cnt_clr = 1'b0; dp_step = 1'($urandom);
        model_result(s, clr);
        check("done_rvalid", r_valid, 1);
        check("done_ready", s_ready, 0);
        check("done_rstep", r_step, s);
        check("done_count", step_count, m_cnt);
        if (wr_mode == 2) begin
            cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_wdata = DW'($urandom);
        end
        tick();
        cfg_we = 1'b0;
        if (wr_mode == 2) begin
            check("cfg_err_done", cfg_err, 1);
            check("weights_frozen_done", dut_w(), model_w());
        end
        check("idle_rvalid", r_valid, 0);
        check("idle_ready", s_ready, 1);
        check("idle_rstep_held", r_step, s);
    endtask

    task automatic run_pattern(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            do_sample(DW'($urandom), DW'($urandom), bits[i], 1'b0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1;
        check("init_ready", s_ready, 0);
        check("init_rvalid", r_valid, 0);
        do_reset();

        // weight bank load
        for (int i = 0; i < 6; i++) cfg_write(3'(i), DW'(i + 1));
        check("t1_weights", dut_w(), 64'h0000_0102_0304_0506);

        // first sample with a step
        do_sample(8'h10, 8'h20, 1'b1, 1'b0, 0, 1'b0);
        check("t2_count", step_count, 1);

        // rejected writes and write+accept
        do_sample(8'h33, 8'h44, 1'b0, 1'b0, 1, 1'b0);
        cfg_write(3'd7, 8'hAA);
        cfg_write(3'd6, 8'hBB);
        do_sample(8'h01, 8'h02, 1'b0, 1'b0, 2, 1'b1);

        // debounce patterns
        do_reset();
        run_pattern(16'b10001, 5);
        check("t4_gap_short", step_count, 1);
        do_reset();
        run_pattern(16'b100001, 6);
        check("t4_gap_ok", step_count, 2);
        do_reset();
        run_pattern(16'b111, 3);
        check("t4_held_high", step_count, 1);

        // clear beats increment; saturation
        do_reset();
        do_sample(8'h05, 8'h06, 1'b1, 1'b1, 0, 1'b0);
        check("t5_clr_wins", step_count, 0);
        do_reset();
        for (int k = 0; k < 5; k++) run_pattern(16'b10000, 5);
        check("t5_saturate", step_count, 3);

        // reset mid-run
        do_reset();
        cfg_write(3'd0, 8'h5A);
        s_valid = 1'b1; s_x = 8'h77; s_y = 8'h88;
        tick();
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rvalid", r_valid, 0);
        check("t6_ready", s_ready, 0);
        check("t6_weights", dut_w(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            check("t6_no_stale_rvalid", r_valid, 0);
            check("t6_ready_after", s_ready, 1);
        end

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) cfg_write(3'($urandom), DW'($urandom));
            if (sel == 1) begin
                cnt_clr = 1'b1;
                tick();
                cnt_clr = 1'b0;
                model_clear();
                check("idle_clr", step_count, 0);
            end
            do_sample(DW'($urandom), DW'($urandom), ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'($urandom));
        end
        check("final_count", step_count, m_cnt);
        check("final_weights", dut_w(), model_w());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
